// File: rtl/rnn_dense_head.sv
// Dense output head of an RNN: streams LEN Q8.8 hidden elements, forms a
// dot product with stored weights plus bias, and emits a hard-sigmoid result.
module rnn_dense_head #(
  parameter int LEN  = 16,
  parameter int FRAC = 8
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        w_write,
  input  logic [3:0]  w_addr,
  input  logic [15:0] w_data,
  input  logic        b_write,
  input  logic [15:0] b_data,
  input  logic        h_valid,
  output logic        h_ready,
  input  logic [15:0] h_data,
  output logic        y_valid,
  input  logic        y_ready,
  output logic [15:0] y_data,
  output logic        y_sat,
  output logic        busy
);

  localparam int IW = (LEN > 1) ? $clog2(LEN) : 1;

  typedef enum logic [2:0] {IDLE, ACC, SCALE, ACT, OUT} state_t;

  state_t             state_q;
  logic [IW-1:0]      idx_q;
  logic signed [39:0] acc_q, acc_d;
  logic signed [15:0] w_q [LEN];
  logic signed [15:0] bias_q;
  logic signed [15:0] x_q, x_d;
  logic [15:0]        y_q, y_d;
  logic               sat_q, sat_d;

  logic signed [31:0] prod;
  logic signed [39:0] sum, shr;
  logic signed [15:0] xq4;
  logic signed [17:0] t;
  logic               h_fire, w_ok, last;

  assign h_ready = (state_q == IDLE) || (state_q == ACC);
  assign h_fire  = h_valid && h_ready;
  assign w_ok    = {1'b0, w_addr} < 5'(LEN);
  assign last    = idx_q == IW'(LEN - 1);
  assign y_valid = state_q == OUT;
  assign busy    = state_q != IDLE;
  assign y_data  = y_q;
  assign y_sat   = sat_q;

  always_comb begin
    // |h*w| <= 2^30, so the low 32 bits of the widened product are exact
    prod  = 32'($signed(h_data)) * 32'(w_q[idx_q]);
    acc_d = ((state_q == IDLE) ? 40'sd0 : acc_q) + 40'(prod);

    sum   = acc_q + (40'(bias_q) <<< FRAC) + (40'sd1 <<< (FRAC - 1));
    shr   = sum >>> FRAC;
    x_d   = shr[15:0];
    sat_d = 1'b0;
    if (shr > 40'sd32767) begin
      x_d   = 16'sh7FFF;
      sat_d = 1'b1;
    end else if (shr < -40'sd32768) begin
      x_d   = 16'sh8000;
      sat_d = 1'b1;
    end

    xq4 = x_q >>> 2;
    t   = 18'(xq4) + 18'sd128;
    if (t < 18'sd0)        y_d = 16'h0000;
    else if (t > 18'sd256) y_d = 16'h0100;
    else                   y_d = t[15:0];
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      idx_q   <= '0;
      acc_q   <= '0;
      x_q     <= '0;
      bias_q  <= '0;
      y_q     <= '0;
      sat_q   <= 1'b0;
      for (int i = 0; i < LEN; i++) w_q[i] <= '0;
    end else begin
      // the product above reads the pre-write weight, so a same-cycle
      // write only becomes visible from the next cycle
      if (h_fire) begin
        acc_q <= acc_d;
        if (last) begin
          idx_q   <= '0;
          state_q <= SCALE;
        end else begin
          idx_q   <= idx_q + IW'(1);
          state_q <= ACC;
        end
      end
      case (state_q)
        IDLE: begin
          if (w_write && w_ok) w_q[w_addr[IW-1:0]] <= $signed(w_data);
          if (b_write)         bias_q <= $signed(b_data);
        end
        SCALE: begin
          x_q     <= x_d;
          sat_q   <= sat_d;
          state_q <= ACT;
        end
        ACT: begin
          y_q     <= y_d;
          state_q <= OUT;
        end
        OUT: if (y_ready) state_q <= IDLE;
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_rnn_dense_head.sv
// Directed bench for rnn_dense_head: expected results queue on stimulus and
// are compared when the head presents y_valid.
module tb_rnn_dense_head;
  localparam int LEN = 16;

  logic        clk = 1'b0;
  logic        rst, w_write, b_write, h_valid, h_ready, y_valid, y_ready, y_sat, busy;
  logic [3:0]  w_addr;
  logic [15:0] w_data, b_data, h_data, y_data;

  typedef struct {logic [15:0] y; logic s;} exp_t;
  exp_t        sb[$];
  logic [15:0] wv[LEN];
  logic [15:0] hv[LEN];
  logic [15:0] bv;
  int          n_assert = 0, n_fail = 0;

  rnn_dense_head #(.LEN(LEN), .FRAC(8)) dut (
    .clk(clk), .rst(rst), .w_write(w_write), .w_addr(w_addr), .w_data(w_data),
    .b_write(b_write), .b_data(b_data), .h_valid(h_valid), .h_ready(h_ready),
    .h_data(h_data), .y_valid(y_valid), .y_ready(y_ready), .y_data(y_data),
    .y_sat(y_sat), .busy(busy)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic load_w(input logic [15:0] d);
    for (int i = 0; i < LEN; i++) begin
      w_write = 1'b1; w_addr = 4'(i); w_data = d;
      tick();
      wv[i] = d;
    end
    w_write = 1'b0;
  endtask

  task automatic wr_b(input logic [15:0] d);
    b_write = 1'b1; b_data = d;
    tick();
    b_write = 1'b0;
    bv = d;
  endtask

  task automatic push(input logic [15:0] y, input logic s);
    exp_t e;
    e.y = y; e.s = s;
    sb.push_back(e);
  endtask

  // Reference: Q16.16 dot product, rounded rescale, saturate, hard sigmoid
  function automatic exp_t model();
    exp_t   e;
    longint acc, x, v;
    acc = 0;
    for (int i = 0; i < LEN; i++)
      acc += longint'($signed(hv[i])) * longint'($signed(wv[i]));
    acc += longint'($signed(bv)) * 256 + 128;
    x = acc >>> 8;
    e.s = 1'b0;
    if (x > 32767)       begin x = 32767;  e.s = 1'b1; end
    else if (x < -32768) begin x = -32768; e.s = 1'b1; end
    v = (x >>> 2) + 128;
    if (v < 0)   v = 0;
    if (v > 256) v = 256;
    e.y = 16'(v);
    return e;
  endfunction

  task automatic send(input bit gaps, input bit lat, input bit wr0, input logic [15:0] wr0d);
    int g;
    for (int i = 0; i < LEN; i++) begin
      if (gaps && (i % 3 == 1)) begin
        h_valid = 1'b0;
        tick(); tick();
      end
      h_valid = 1'b1; h_data = hv[i];
      if (wr0 && i == 0) begin w_write = 1'b1; w_addr = 4'd0; w_data = wr0d; end
      g = 0;
      while (!h_ready && g < 50) begin tick(); g++; end
      if (!h_ready) chk("h_ready_timeout", h_ready, 1);
      tick();
      w_write = 1'b0;
    end
    h_valid = 1'b0;
    if (lat) begin
      chk("lat_scale", y_valid, 0);
      tick();
      chk("lat_act", y_valid, 0);
      tick();
      chk("lat_out", y_valid, 1);
    end
  endtask

  task automatic collect(input string tag);
    int   g;
    exp_t e;
    g = 0;
    while (!y_valid && g < 30) begin tick(); g++; end
    chk({tag, "_valid"}, y_valid, 1);
    if (sb.size() == 0) begin
      chk({tag, "_sb_empty"}, 0, 1);
    end else begin
      e = sb.pop_front();
      chk({tag, "_y"}, y_data, e.y);
      chk({tag, "_sat"}, y_sat, e.s);
      y_ready = 1'b1;
      tick();
      y_ready = 1'b0;
      chk({tag, "_idle"}, {busy, y_valid}, 0);
      chk({tag, "_hold"}, y_data, e.y);
    end
  endtask

  initial begin
    rst = 1'b1; w_write = 0; w_addr = 0; w_data = 0; b_write = 0; b_data = 0;
    h_valid = 0; h_data = 0; y_ready = 0; bv = 0;
    for (int i = 0; i < LEN; i++) begin wv[i] = 0; hv[i] = 0; end
    tick(); tick();
    rst = 1'b0;
    chk("rst_h_ready", h_ready, 1);
    chk("rst_busy", busy, 0);
    chk("rst_y_valid", y_valid, 0);
    chk("rst_y_data", y_data, 0);
    chk("rst_y_sat", y_sat, 0);

    // unit weights, zero input -> midpoint, with latency check
    load_w(16'h0100); wr_b(16'h0000);
    for (int i = 0; i < LEN; i++) hv[i] = 16'h0000;
    push(16'h0080, 0); send(0, 1, 0, 0); collect("zero_in");

    // +1.0 everywhere -> x=0x1000, top clamp; -1.0 -> bottom clamp
    for (int i = 0; i < LEN; i++) hv[i] = 16'h0100;
    push(16'h0100, 0); send(0, 1, 0, 0); collect("pos_one");
    chk("pos_x", dut.x_q, 16'h1000);
    for (int i = 0; i < LEN; i++) hv[i] = 16'hFF00;
    push(16'h0000, 0); send(0, 0, 0, 0); collect("neg_one");

    // full-scale positive -> saturation
    load_w(16'h7FFF);
    for (int i = 0; i < LEN; i++) hv[i] = 16'h7FFF;
    push(16'h0100, 1); send(0, 1, 0, 0); collect("sat");
    chk("sat_x", dut.x_q, 16'h7FFF);

    // zero weights, bias 1.0, arbitrary h with gaps
    load_w(16'h0000); wr_b(16'h0100);
    for (int i = 0; i < LEN; i++) hv[i] = 16'($urandom());
    push(16'h00C0, 0); send(1, 0, 0, 0); collect("bias_only");
    chk("bias_x", dut.x_q, 16'h0100);

    // random data; weight 0 rewritten on the first handshake cycle
    for (int i = 0; i < LEN; i++) begin
      w_write = 1'b1; w_addr = 4'(i); w_data = 16'($urandom_range(0, 1023)) - 16'd512;
      wv[i] = w_data; tick();
    end
    w_write = 1'b0;
    wr_b(16'($urandom_range(0, 511)) - 16'd256);
    for (int i = 0; i < LEN; i++) hv[i] = 16'($urandom_range(0, 1023)) - 16'd512;
    sb.push_back(model()); send(0, 1, 1, 16'h0300); collect("rnd_oldw");
    wv[0] = 16'h0300;
    for (int i = 0; i < LEN; i++) hv[i] = 16'($urandom_range(0, 1023)) - 16'd512;
    sb.push_back(model()); send(1, 0, 0, 0); collect("rnd_neww");

    // stall in OUT; weight write there must be ignored
    load_w(16'h0100); wr_b(16'h0000);
    for (int i = 0; i < LEN; i++) hv[i] = 16'h0100;
    push(16'h0100, 0); send(0, 1, 0, 0);
    for (int c = 0; c < 5; c++) begin
      w_write = 1'b1; w_addr = 4'd0; w_data = 16'h7FFF;
      chk("stall_valid", y_valid, 1);
      chk("stall_y", y_data, 16'h0100);
      chk("stall_h_ready", h_ready, 0);
      tick();
    end
    w_write = 1'b0;
    collect("stall");
    for (int i = 0; i < LEN; i++) hv[i] = 16'h0000;
    hv[0] = 16'h0100;
    push(16'h00C0, 0); send(0, 0, 0, 0); collect("w0_unchanged");

    // abort mid-accumulation with reset
    for (int i = 0; i < 7; i++) begin
      h_valid = 1'b1; h_data = 16'h0100; tick();
    end
    h_valid = 1'b0;
    chk("abort_busy", busy, 1);
    rst = 1'b1; tick(); rst = 1'b0;
    chk("abort_h_ready", h_ready, 1);
    chk("abort_busy0", busy, 0);
    chk("abort_y_data", y_data, 0);
    chk("abort_y_sat", y_sat, 0);
    for (int i = 0; i < LEN; i++) wv[i] = 16'h0000;
    wr_b(16'h0100);
    for (int i = 0; i < LEN; i++) hv[i] = 16'($urandom());
    push(16'h00C0, 0); send(0, 1, 0, 0); collect("post_abort");

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
